// File: rtl/regfile_alu_pkg.sv
// Shared definitions for the register-file + ALU block: opcodes and flag bit positions.
package regfile_alu_pkg;

  // ALU operation codes; values 10..15 are unassigned and produce a zero result.
  typedef enum logic [3:0] {
    ALU_AND = 4'd0,
    ALU_OR  = 4'd1,
    ALU_XOR = 4'd2,
    ALU_NOR = 4'd3,
    ALU_ADD = 4'd4,
    ALU_SUB = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9
  } alu_op_e;

  // Bit positions inside the 4-bit flags vector {ZF, CF, OF, SF}.
  localparam int FLAG_ZF = 3;
  localparam int FLAG_CF = 2;
  localparam int FLAG_OF = 1;
  localparam int FLAG_SF = 0;
  localparam int FLAGS_W = 4;

endpackage

// File: rtl/alu_param.sv
// Purely combinational ALU. Produces the result plus the carry/borrow and signed
// overflow bits; zero and sign flags are derived from the result by the caller.
module alu_param
  import regfile_alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        op,
  output logic [DATA_W-1:0] result,
  output logic              cf,
  output logic              of
);

  localparam int SH_W = $clog2(DATA_W);
  localparam int MSB  = DATA_W - 1;

  logic [DATA_W:0] w_sum;
  logic [DATA_W:0] w_diff;
  logic [SH_W-1:0] w_shamt;

  // One extra bit on the add/subtract gives the carry-out and, for SUB, the unsigned borrow.
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = {1'b0, a} - {1'b0, b};
  assign w_shamt = b[SH_W-1:0];

  // Opcode decode; carry and overflow stay 0 for everything but ADD/SUB.
  always_comb begin
    result = '0;
    cf     = 1'b0;
    of     = 1'b0;
    case (op)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_XOR: result = a ^ b;
      ALU_NOR: result = ~(a | b);
      ALU_ADD: begin
        result = w_sum[DATA_W-1:0];
        cf     = w_sum[DATA_W];
        of     = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      ALU_SUB: begin
        result = w_diff[DATA_W-1:0];
        cf     = w_diff[DATA_W];
        of     = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      ALU_SLT: result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLL: result = a << w_shamt;
      ALU_SRL: result = a >> w_shamt;
      ALU_SRA: result = $signed(a) >>> w_shamt;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_alu_param.sv
// Register file with operand latches A/B, an ALU stage latching F and flags, and a
// write-back path from F or external data. Register 0 can be hard-wired to zero.
//
// Strobe semantics: rr_en, f_en and wb_en are single-cycle enables sampled on the
// rising edge; there is no backpressure. f_valid pulses for exactly one cycle after
// each f_en. When strobes coincide, every stage sees the pre-edge value of the
// others (ALU uses old A/B, write-back of F uses old F), except that an operand read
// of the register being written in the same cycle returns the write data.
module regfile_alu_param
  import regfile_alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rr_en,
  input  logic              f_en,
  input  logic              wb_en,
  input  logic              wb_sel,
  input  logic [3:0]        alu_op,
  input  logic [ADDR_W-1:0] r_addr_a,
  input  logic [ADDR_W-1:0] r_addr_b,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] a_q,
  output logic [DATA_W-1:0] b_q,
  output logic [DATA_W-1:0] f_q,
  output logic [3:0]        flags,
  output logic              f_valid,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_rf [DEPTH];
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [DATA_W-1:0] r_f;
  logic [FLAGS_W-1:0] r_flags;
  logic              r_f_valid;

  logic [DATA_W-1:0] w_wdata;
  logic              w_wr_ok;
  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic [DATA_W-1:0] w_alu_res;
  logic              w_alu_cf;
  logic              w_alu_of;
  logic [FLAGS_W-1:0] w_flags;

  // True for the hard-wired zero register when that feature is enabled.
  function automatic logic is_zero_addr(input logic [ADDR_W-1:0] addr);
    return ZERO_REG && (addr == '0);
  endfunction

  // Write-back source; F here is the value before this edge's ALU update.
  assign w_wdata = wb_sel ? din : r_f;
  assign w_wr_ok = wb_en && !is_zero_addr(w_addr);

  // Operand reads with write-first bypass; the zero register wins over the bypass.
  assign w_rd_a = is_zero_addr(r_addr_a) ? '0 :
                  (w_wr_ok && (w_addr == r_addr_a)) ? w_wdata : r_rf[r_addr_a];
  assign w_rd_b = is_zero_addr(r_addr_b) ? '0 :
                  (w_wr_ok && (w_addr == r_addr_b)) ? w_wdata : r_rf[r_addr_b];

  // Debug port reads the array directly, so a write shows up only after its edge.
  assign dbg_data = is_zero_addr(dbg_addr) ? '0 : r_rf[dbg_addr];

  alu_param #(
    .DATA_W (DATA_W)
  ) u_alu (
    .a      (r_a),
    .b      (r_b),
    .op     (alu_op),
    .result (w_alu_res),
    .cf     (w_alu_cf),
    .of     (w_alu_of)
  );

  // Assemble the flag vector from the ALU outputs and the result itself.
  always_comb begin
    w_flags          = '0;
    w_flags[FLAG_ZF] = (w_alu_res == '0);
    w_flags[FLAG_CF] = w_alu_cf;
    w_flags[FLAG_OF] = w_alu_of;
    w_flags[FLAG_SF] = w_alu_res[DATA_W-1];
  end

  // Register file storage: cleared on reset, otherwise one write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rf[i] <= '0;
      end
    end else if (w_wr_ok) begin
      r_rf[w_addr] <= w_wdata;
    end
  end

  // Operand, result and flag registers; reset discards any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_f       <= '0;
      r_flags   <= '0;
      r_f_valid <= 1'b0;
    end else begin
      if (rr_en) begin
        r_a <= w_rd_a;
        r_b <= w_rd_b;
      end
      if (f_en) begin
        r_f     <= w_alu_res;
        r_flags <= w_flags;
      end
      r_f_valid <= f_en;
    end
  end

  assign a_q     = r_a;
  assign b_q     = r_b;
  assign f_q     = r_f;
  assign flags   = r_flags;
  assign f_valid = r_f_valid;

endmodule

// File: tb/tb_regfile_alu_param.sv
// Bench for regfile_alu_param: directed scenarios plus a randomized run checked
// against an arithmetic reference model, and a 16-bit build for the overflow case.
module tb_regfile_alu_param;
  import regfile_alu_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rr_en, f_en, wb_en, wb_sel;
  logic [3:0]  alu_op;
  logic [4:0]  r_addr_a, r_addr_b, w_addr, dbg_addr;
  logic [31:0] din, a_q, b_q, f_q, dbg_data;
  logic [3:0]  flags;
  logic        f_valid;

  logic        rst_16, rr_en_16, f_en_16, wb_en_16, wb_sel_16;
  logic [3:0]  alu_op_16;
  logic [4:0]  r_addr_a_16, r_addr_b_16, w_addr_16, dbg_addr_16;
  logic [15:0] din_16, a_q_16, b_q_16, f_q_16, dbg_data_16;
  logic [3:0]  flags_16;
  logic        f_valid_16;

  int checks = 0;
  int errors = 0;

  regfile_alu_param dut (
    .clk(clk), .rst(rst), .rr_en(rr_en), .f_en(f_en), .wb_en(wb_en), .wb_sel(wb_sel),
    .alu_op(alu_op), .r_addr_a(r_addr_a), .r_addr_b(r_addr_b), .w_addr(w_addr),
    .dbg_addr(dbg_addr), .din(din), .a_q(a_q), .b_q(b_q), .f_q(f_q), .flags(flags),
    .f_valid(f_valid), .dbg_data(dbg_data)
  );

  regfile_alu_param #(.DATA_W(16), .ADDR_W(5), .ZERO_REG(1'b1)) dut16 (
    .clk(clk), .rst(rst_16), .rr_en(rr_en_16), .f_en(f_en_16), .wb_en(wb_en_16),
    .wb_sel(wb_sel_16), .alu_op(alu_op_16), .r_addr_a(r_addr_a_16), .r_addr_b(r_addr_b_16),
    .w_addr(w_addr_16), .dbg_addr(dbg_addr_16), .din(din_16), .a_q(a_q_16), .b_q(b_q_16),
    .f_q(f_q_16), .flags(flags_16), .f_valid(f_valid_16), .dbg_data(dbg_data_16)
  );

  // ---------------- reference model ----------------
  logic [31:0] m_rf [32];
  logic [31:0] m_a, m_b, m_f;
  logic [3:0]  m_flags;
  logic        m_fv;

  // Returns {ZF, CF, OF, SF, result} from plain integer arithmetic.
  function automatic logic [35:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic [63:0] u;
    longint      sa, sb, s;
    logic        cf, of;
    sa = $signed(a);
    sb = $signed(b);
    r  = '0;
    cf = 1'b0;
    of = 1'b0;
    case (op)
      4'd0: r = a & b;
      4'd1: r = a | b;
      4'd2: r = a ^ b;
      4'd3: r = ~(a | b);
      4'd4: begin
        u  = {32'd0, a} + {32'd0, b};
        r  = u[31:0];
        cf = (u > 64'h0000_0000_FFFF_FFFF);
        s  = sa + sb;
        of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd5: begin
        r  = a - b;
        cf = (a < b);
        s  = sa - sb;
        of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd7: r = a << b[4:0];
      4'd8: r = a >> b[4:0];
      4'd9: begin
        s = sa >>> b[4:0];
        r = s[31:0];
      end
      default: r = '0;
    endcase
    return {(r == 32'd0), cf, of, r[31], r};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic idle();
    rr_en = 1'b0; f_en = 1'b0; wb_en = 1'b0; wb_sel = 1'b0;
  endtask

  // Advance one clock, stepping the model with the inputs currently applied.
  task automatic tick();
    logic [31:0] wdata, na, nb;
    logic [35:0] res;
    if (rst) begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;
      m_a = '0; m_b = '0; m_f = '0; m_flags = '0; m_fv = 1'b0;
    end else begin
      wdata = wb_sel ? din : m_f;
      na = m_a;
      nb = m_b;
      if (rr_en) begin
        if (r_addr_a == 0) na = '0;
        else if (wb_en && w_addr == r_addr_a) na = wdata;
        else na = m_rf[r_addr_a];
        if (r_addr_b == 0) nb = '0;
        else if (wb_en && w_addr == r_addr_b) nb = wdata;
        else nb = m_rf[r_addr_b];
      end
      if (f_en) begin
        res = alu_ref(alu_op, m_a, m_b);
        m_f = res[31:0];
        m_flags = res[35:32];
      end
      m_fv = f_en;
      if (wb_en && w_addr != 0) m_rf[w_addr] = wdata;
      m_a = na;
      m_b = nb;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [4:0] addr, input logic [31:0] data);
    idle();
    wb_en = 1'b1; wb_sel = 1'b1; w_addr = addr; din = data;
    tick();
    idle();
  endtask

  task automatic rd_ops(input logic [4:0] aa, input logic [4:0] bb);
    idle();
    rr_en = 1'b1; r_addr_a = aa; r_addr_b = bb;
    tick();
    idle();
  endtask

  task automatic do_alu(input logic [3:0] op);
    idle();
    f_en = 1'b1; alu_op = op;
    tick();
    idle();
  endtask

  task automatic tick16();
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    wr_reg(5'd7, 32'h1234);
    rd_ops(5'd7, 5'd7);
    // Reset with every strobe active: reset must win.
    rst = 1'b1; rr_en = 1'b1; f_en = 1'b1; wb_en = 1'b1; wb_sel = 1'b1;
    w_addr = 5'd9; din = 32'hDEAD_BEEF; alu_op = 4'd4;
    tick();
    rst = 1'b0;
    idle();
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      checks++;
      if (dbg_data !== 32'd0) begin
        errors++;
        $display("FAIL reset_rf[%0d]: got %h want 0", i, dbg_data);
      end
    end
    checks++;
    if (flags !== 4'd0) begin errors++; $display("FAIL reset_flags: got %b want 0000", flags); end
    checks++;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL reset_f_valid: got %b want 0", f_valid); end
    checks++;
    if ({a_q, b_q, f_q} !== 96'd0) begin
      errors++;
      $display("FAIL reset_abf: got a=%h b=%h f=%h want 0", a_q, b_q, f_q);
    end
    // First strobe after reset is honoured on the next edge.
    wr_reg(5'd1, 32'h0000_0042);
    dbg_addr = 5'd1;
    #1;
    checks++;
    if (dbg_data !== 32'h42) begin errors++; $display("FAIL post_reset_write: got %h want 42", dbg_data); end
  endtask

  task automatic test_add_overflow();
    wr_reg(5'd1, 32'h7FFF_FFFF);
    wr_reg(5'd2, 32'h0000_0001);
    rd_ops(5'd1, 5'd2);
    do_alu(4'd4);
    checks++;
    if (f_q !== 32'h8000_0000) begin errors++; $display("FAIL add_ovf_f: got %h want 80000000", f_q); end
    checks++;
    if (flags !== 4'b0011) begin errors++; $display("FAIL add_ovf_flags: got %b want 0011", flags); end
    checks++;
    if (f_valid !== 1'b1) begin errors++; $display("FAIL add_f_valid_pulse: got %b want 1", f_valid); end
    tick();
    checks++;
    if (f_valid !== 1'b0) begin errors++; $display("FAIL add_f_valid_drop: got %b want 0", f_valid); end
    checks++;
    if (flags !== 4'b0011) begin errors++; $display("FAIL add_flags_hold: got %b want 0011", flags); end
  endtask

  task automatic test_sub();
    wr_reg(5'd1, 32'd5);
    wr_reg(5'd2, 32'd5);
    rd_ops(5'd1, 5'd2);
    do_alu(4'd5);
    checks++;
    if (f_q !== 32'd0) begin errors++; $display("FAIL sub_eq_f: got %h want 0", f_q); end
    checks++;
    if (flags !== 4'b1000) begin errors++; $display("FAIL sub_eq_flags: got %b want 1000", flags); end
    wr_reg(5'd1, 32'd3);
    rd_ops(5'd1, 5'd2);
    do_alu(4'd5);
    checks++;
    if (f_q !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_borrow_f: got %h want fffffffe", f_q); end
    checks++;
    if (flags !== 4'b0101) begin errors++; $display("FAIL sub_borrow_flags: got %b want 0101", flags); end
  endtask

  task automatic test_zero_reg();
    wr_reg(5'd0, 32'hABCD);
    dbg_addr = 5'd0;
    #1;
    checks++;
    if (dbg_data !== 32'd0) begin errors++; $display("FAIL zero_reg_dbg: got %h want 0", dbg_data); end
    rd_ops(5'd1, 5'd1);
    idle();
    wb_en = 1'b1; wb_sel = 1'b1; w_addr = 5'd0; din = 32'hABCD;
    rr_en = 1'b1; r_addr_a = 5'd0; r_addr_b = 5'd1;
    tick();
    idle();
    checks++;
    if (a_q !== 32'd0) begin errors++; $display("FAIL zero_reg_bypass: got %h want 0", a_q); end
  endtask

  task automatic test_shifts();
    wr_reg(5'd3, 32'h8000_0000);
    wr_reg(5'd4, 32'd4);
    rd_ops(5'd3, 5'd4);
    do_alu(4'd9);
    checks++;
    if (f_q !== 32'hF800_0000) begin errors++; $display("FAIL sra: got %h want f8000000", f_q); end
    checks++;
    if (flags !== 4'b0001) begin errors++; $display("FAIL sra_flags: got %b want 0001", flags); end
    do_alu(4'd8);
    checks++;
    if (f_q !== 32'h0800_0000) begin errors++; $display("FAIL srl: got %h want 08000000", f_q); end
    do_alu(4'd7);
    checks++;
    if (f_q !== 32'd0) begin errors++; $display("FAIL sll: got %h want 0", f_q); end
    do_alu(4'd8);
    do_alu(4'd12);
    checks++;
    if (f_q !== 32'd0) begin errors++; $display("FAIL op12: got %h want 0", f_q); end
    checks++;
    if (flags !== 4'b1000) begin errors++; $display("FAIL op12_flags: got %b want 1000", flags); end
  endtask

  task automatic test_back_to_back();
    // Write-first bypass of external data into operand A.
    idle();
    wb_en = 1'b1; wb_sel = 1'b1; w_addr = 5'd4; din = 32'h55;
    rr_en = 1'b1; r_addr_a = 5'd4; r_addr_b = 5'd0;
    tick();
    idle();
    checks++;
    if (a_q !== 32'h55) begin errors++; $display("FAIL bypass_din: got %h want 55", a_q); end
    // Set A=10, B=3, F=7, r8=100.
    wr_reg(5'd6, 32'd10);
    wr_reg(5'd7, 32'd3);
    rd_ops(5'd6, 5'd7);
    do_alu(4'd5);
    wr_reg(5'd8, 32'd100);
    // All three strobes at once; F written back to r9 and bypassed into A.
    idle();
    rr_en = 1'b1; r_addr_a = 5'd9; r_addr_b = 5'd8;
    f_en = 1'b1; alu_op = 4'd4;
    wb_en = 1'b1; wb_sel = 1'b0; w_addr = 5'd9;
    tick();
    idle();
    dbg_addr = 5'd9;
    #1;
    checks++;
    if (f_q !== 32'd13) begin errors++; $display("FAIL concurrent_old_ab: got %0d want 13", f_q); end
    checks++;
    if (a_q !== 32'd7) begin errors++; $display("FAIL concurrent_a_old_f: got %0d want 7", a_q); end
    checks++;
    if (b_q !== 32'd100) begin errors++; $display("FAIL concurrent_b: got %0d want 100", b_q); end
    checks++;
    if (dbg_data !== 32'd7) begin errors++; $display("FAIL wb_old_f: got %0d want 7", dbg_data); end
    do_alu(4'd4);
    checks++;
    if (f_q !== 32'd107) begin errors++; $display("FAIL next_add: got %0d want 107", f_q); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 500; n++) begin
      rst    = ($urandom_range(0, 59) == 0);
      rr_en  = $urandom_range(0, 1) == 1;
      f_en   = $urandom_range(0, 1) == 1;
      wb_en  = $urandom_range(0, 1) == 1;
      wb_sel = $urandom_range(0, 1) == 1;
      alu_op = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        r_addr_a = 5'($urandom_range(0, 3));
        r_addr_b = 5'($urandom_range(0, 3));
        w_addr   = 5'($urandom_range(0, 3));
      end else begin
        r_addr_a = 5'($urandom_range(0, 31));
        r_addr_b = 5'($urandom_range(0, 31));
        w_addr   = 5'($urandom_range(0, 31));
      end
      case ($urandom_range(0, 5))
        0: din = 32'h7FFF_FFFF;
        1: din = 32'h8000_0000;
        2: din = 32'($urandom_range(0, 40));
        3: din = 32'hFFFF_FFFF;
        default: din = $urandom;
      endcase
      tick();
      rst = 1'b0;
      dbg_addr = 5'($urandom_range(0, 31));
      #1;
      checks++;
      if (a_q !== m_a) begin errors++; $display("FAIL rand_a[%0d]: got %h want %h", n, a_q, m_a); end
      checks++;
      if (b_q !== m_b) begin errors++; $display("FAIL rand_b[%0d]: got %h want %h", n, b_q, m_b); end
      checks++;
      if (f_q !== m_f) begin errors++; $display("FAIL rand_f[%0d]: got %h want %h", n, f_q, m_f); end
      checks++;
      if (flags !== m_flags) begin
        errors++;
        $display("FAIL rand_flags[%0d]: got %b want %b", n, flags, m_flags);
      end
      checks++;
      if (f_valid !== m_fv) begin
        errors++;
        $display("FAIL rand_f_valid[%0d]: got %b want %b", n, f_valid, m_fv);
      end
      checks++;
      if (dbg_data !== ((dbg_addr == 0) ? 32'd0 : m_rf[dbg_addr])) begin
        errors++;
        $display("FAIL rand_dbg[%0d]: got %h want %h", n, dbg_data,
                 (dbg_addr == 0) ? 32'd0 : m_rf[dbg_addr]);
      end
    end
    idle();
  endtask

  task automatic test_width16();
    rst_16 = 1'b1; rr_en_16 = 1'b0; f_en_16 = 1'b0; wb_en_16 = 1'b0; wb_sel_16 = 1'b1;
    alu_op_16 = 4'd4; r_addr_a_16 = 5'd1; r_addr_b_16 = 5'd2; w_addr_16 = 5'd1;
    dbg_addr_16 = 5'd1; din_16 = 16'h7FFF;
    tick16();
    rst_16 = 1'b0;
    wb_en_16 = 1'b1; w_addr_16 = 5'd1; din_16 = 16'h7FFF;
    tick16();
    w_addr_16 = 5'd2; din_16 = 16'h0001;
    tick16();
    wb_en_16 = 1'b0; rr_en_16 = 1'b1;
    tick16();
    rr_en_16 = 1'b0; f_en_16 = 1'b1;
    tick16();
    f_en_16 = 1'b0;
    checks++;
    if (f_q_16 !== 16'h8000) begin errors++; $display("FAIL w16_add_f: got %h want 8000", f_q_16); end
    checks++;
    if (flags_16 !== 4'b0011) begin errors++; $display("FAIL w16_add_flags: got %b want 0011", flags_16); end
    // Carry without overflow: 0xFFFF + 1.
    wb_en_16 = 1'b1; w_addr_16 = 5'd1; din_16 = 16'hFFFF;
    tick16();
    wb_en_16 = 1'b0; rr_en_16 = 1'b1;
    tick16();
    rr_en_16 = 1'b0; f_en_16 = 1'b1;
    tick16();
    f_en_16 = 1'b0;
    checks++;
    if (f_q_16 !== 16'h0000) begin errors++; $display("FAIL w16_carry_f: got %h want 0000", f_q_16); end
    checks++;
    if (flags_16 !== 4'b1100) begin errors++; $display("FAIL w16_carry_flags: got %b want 1100", flags_16); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    idle();
    alu_op = 4'd0; r_addr_a = '0; r_addr_b = '0; w_addr = '0; dbg_addr = '0; din = '0;
    rst_16 = 1'b1; rr_en_16 = 1'b0; f_en_16 = 1'b0; wb_en_16 = 1'b0; wb_sel_16 = 1'b0;
    alu_op_16 = '0; r_addr_a_16 = '0; r_addr_b_16 = '0; w_addr_16 = '0; dbg_addr_16 = '0;
    din_16 = '0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_add_overflow();
    test_sub();
    test_zero_reg();
    test_shifts();
    test_back_to_back();
    test_random();
    test_width16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_alu_param.md
REGFILE_ALU_PARAM -- requirements
Module: regfile_alu_param

Interface
REQ-001 Parameter DATA_W, default 32, datapath width; legal range 8..64.
REQ-002 Parameter ADDR_W, default 5, register address width; depth 2**ADDR_W.
REQ-003 Parameter ZERO_REG, default 1; when 1, register 0 always reads zero.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 rr_en  in  1  latch operands: A <= RF[r_addr_a], B <= RF[r_addr_b].
REQ-007 f_en  in  1  compute ALU(A,B,alu_op); latch result into F and flags.
REQ-008 wb_en  in  1  write-back strobe to RF[w_addr].
REQ-009 wb_sel  in  1  write-back source: 0 = F, 1 = din.
REQ-010 alu_op  in  4  operation code.
REQ-011 r_addr_a, r_addr_b, w_addr, dbg_addr  in  ADDR_W  addresses.
REQ-012 din  in  DATA_W  external write data.
REQ-013 a_q, b_q, f_q  out  DATA_W  operand and result registers.
REQ-014 flags  out  4  {ZF, CF, OF, SF}, registered.
REQ-015 f_valid  out  1  one-cycle pulse, asserted the cycle after f_en.
REQ-016 dbg_data  out  DATA_W  combinational read of RF[dbg_addr], for display.

Function
REQ-017 The strobes are single-clock enables; the block has no derived or gated clocks.
REQ-018 The block latches A/B one cycle after rr_en, and F/flags/f_valid one cycle after f_en.
REQ-019 ALU ops:
- 0 AND, 1 OR, 2 XOR, 3 NOR
- 4 ADD, 5 SUB (A-B)
- 6 SLT: signed, result 1 or 0
- 7 SLL, 8 SRL, 9 SRA: shift amount B[$clog2(DATA_W)-1:0]
- 10..15: result 0
REQ-020 Flag rules:
- ZF = (result == 0)
- SF = result[DATA_W-1]
- CF = carry-out for ADD; borrow (A<B unsigned) for SUB; 0 for all other ops
- OF = signed overflow for ADD/SUB; 0 for all other ops
REQ-021 Flags change only on f_en and otherwise hold their value.
REQ-022 With ZERO_REG=1, writes to address 0 are dropped, and reads of address 0 (operand or dbg) return 0.
REQ-023 f_en together with rr_en: the ALU uses the pre-update A/B.
REQ-024 wb_en with wb_sel=0 together with f_en: the pre-update F is written.
REQ-025 rr_en and wb_en in the same cycle with a matching address: the operand latches the write data (write-first bypass), except for address 0 when ZERO_REG=1.
REQ-026 dbg_data reflects a write on the cycle after that write's edge; it does not bypass.
REQ-027 Arithmetic is modulo 2**DATA_W; carry is taken from a DATA_W+1 bit sum.

Reset
REQ-028 On rst high at a clock edge, the block clears all RF entries, A, B, F, flags and f_valid to 0.
REQ-029 rst takes priority over all strobes in the same cycle; an operation in flight is discarded.
REQ-030 After rst deasserts, the first strobe is honoured on the next edge.

Structure
REQ-031 The ALU opcode constants and flag bit indices live in the shared package regfile_alu_pkg.
REQ-032 The combinational ALU is the sub-module alu_param (DATA_W parameter; outputs result, cf, of).
REQ-033 The register file is an inferred array inside regfile_alu_param; it is not a separate module.

Verification
REQ-034 Reset, then dbg_addr sweep 0..31 -> dbg_data=0 for every address; flags=0; f_valid=0.
REQ-035 din=0x7FFFFFFF written to r1, din=1 written to r2; rr_en a=1,b=2; f_en op=ADD -> f_q=0x80000000, flags ZF0 CF0 OF1 SF1.
REQ-036 r1=5, r2=5; SUB -> f_q=0, ZF=1, CF=0; then r1=3, r2=5, SUB -> f_q=0xFFFFFFFE, CF=1, SF=1, OF=0.
REQ-037 wb_sel=1 din=0xABCD w_addr=0 with ZERO_REG=1 -> dbg r0 reads 0; same write with rr_en a=0 in the same cycle -> a_q=0.
REQ-038 r3=0x80000000; B=4; SRA -> 0xF8000000; SRL -> 0x08000000; op=12 -> f_q=0, ZF=1.
REQ-039 wb_en w_addr=4 din=0x55 with rr_en a=4 in the same cycle -> a_q=0x55 next cycle; DATA_W=16 build reruns REQ-035 scaled (0x7FFF+1 -> OF=1).
